mem_read_responder: RTL
=======================

# mem_read_responder

- Pipelined main-memory responder: the memory end of the cache-fill protocol.
- Accepts one word read or write per cycle on a byte-addressed 16-bit bus.
- Returns each read word on `data_out` with a one-cycle `data_valid` pulse exactly LATENCY cycles later.
- Sits below the I- and D-cache fill FSMs as the shared memory model; it is what drives their `memory_data`/`memory_data_valid` inputs.

## Interface

**Parameters**
- `LATENCY`, 4: cycles from request edge to `data_valid`; legal range 1..8.
- `WORD_ADDR_BITS`, 15: word-index width; depth = 2^WORD_ADDR_BITS 16-bit words.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `enable`, input, 1: request strobe, sampled at the rising edge.
- `wr`, input, 1: 1 = write, 0 = read; meaningful only when `enable` = 1.
- `addr`, input, 16: byte address; `addr[0]` ignored.
- `data_in`, input, 16: write data.
- `data_out`, output, 16: read data, registered.
- `data_valid`, output, 1: `data_out` holds a returned read word this cycle.
- `resp_addr`, output, 16: byte address of the returned word. Present only with `MEM_RESP_ADDR_ECHO_EN`.

## Operation

- **Word index:** `addr[WORD_ADDR_BITS:1]`. Address bits above this are ignored, so the array aliases (wraps) modulo its depth.
- **Write** (`enable` = 1, `wr` = 1): `data_in` stored at the edge. No response and no `data_valid`.
- **Read** (`enable` = 1, `wr` = 0): array word read at the request edge and pushed into a LATENCY-deep valid/data shift pipeline. Stage 0 is loaded at the request edge.
- **Snapshot semantics:** returned data is the array contents at the request edge. A write to the same word after the request does not alter the in-flight word. A write in the cycle before a read to the same word is visible to that read.
- **Throughput:** back-to-back reads, one per cycle, with no bubbles. A burst of N reads yields N consecutive `data_valid` cycles.
- **Write during in-flight reads:** allowed. Writes create a bubble (`data_valid` = 0) in the corresponding return slot.
- **Idle** (`enable` = 0): pushes an invalid entry.
- **No backpressure:** the requester must accept every response.
- **`data_out` when `data_valid` = 0:** holds its last returned value; it is 0 after reset.
- **Array:** not reset. Contents are undefined until written. Read of an unwritten word returns X in simulation and is not checked.

## Timing

- **Read latency:** request sampled at edge E; `data_valid` = 1 and `data_out` valid from edge E+LATENCY until edge E+LATENCY+1.
- **Fill-FSM example:** with LATENCY = 4, a fill issuing 8 consecutive word addresses sees `data_valid` on cycles 4..11 after the first request.
- **Write commit:** visible to a read sampled on the following edge.
- **Reset values:** `data_out` = 16'h0000, `data_valid` = 0, all pipeline valid bits = 0. With `MEM_RESP_ADDR_ECHO_EN`, `resp_addr` = 16'h0000.
- **Reset mid-operation:** asserting `rst_n` low clears all in-flight reads asynchronously. No `data_valid` pulse is produced for any request accepted before reset. The array is left untouched.
- **After deassertion:** the first request is sampled on the first rising edge with `rst_n` = 1.

## Configuration

- **`MEM_RESP_ADDR_ECHO_EN` defined:**
  - Each pipeline stage also carries the request byte address, with `addr[0]` forced to 0.
  - `resp_addr` presents it aligned with `data_out` and holds it when `data_valid` = 0.
  - This lets the fill FSM and benches check out-of-order or misrouted returns.
- **Not defined:** `resp_addr` port and its pipeline storage are absent. All other behaviour is identical.

## Test plan

1. **Basic read:** write 16'hBEEF @ 16'h0010; idle 1 cycle; read @ 16'h0010 at edge E. Expect `data_valid` only in cycle E+4 (LATENCY = 4) with `data_out` = 16'hBEEF; `data_out` stays 16'hBEEF afterwards with `data_valid` = 0.
2. **Cache-line burst:** write 16'h1000..16'h1007 to 16'h0200..16'h020E; read those 8 addresses on consecutive edges. Expect 8 consecutive `data_valid` cycles returning 16'h1000..16'h1007 in order. With the macro, `resp_addr` = 16'h0200..16'h020E.
3. **Snapshot and bubble:** read @ 16'h0040 (holding 16'hAAAA), then next cycle write 16'h5555 @ 16'h0040, then read @ 16'h0040. Expect returns 16'hAAAA, a bubble cycle, then 16'h5555.
4. **Odd address and aliasing:** write 16'h1234 @ 16'h0021, then read @ 16'h0020. Expect 16'h1234. With `WORD_ADDR_BITS` = 4, reading @ 16'h0060 also returns the word stored @ 16'h0020... only if 16'h0060 aliases it; use 16'h0040 vs 16'h0000 to confirm wrap.
5. **Reset mid-burst:** issue 3 reads, then pulse `rst_n` low asynchronously mid-cycle 2 cycles later. Expect `data_valid` = 0 and `data_out` = 0 immediately, and no `data_valid` for any of the 3 reads. A read issued after deassertion returns normally 4 cycles later.
6. **Latency sweep:** for LATENCY = 1 and LATENCY = 8, repeat scenario 1 and check `data_valid` at exactly E+1 and E+8 respectively.

Source files
------------

// File: rtl/mem_read_responder.sv
// mem_read_responder: pipelined main-memory model at the bottom of the cache-fill path.
// One word read or write per cycle. A read returns its word on data_out with a
// single-cycle data_valid pulse exactly LATENCY cycles after the request edge.
// Optional feature: define MEM_RESP_ADDR_ECHO_EN to add the resp_addr output, which
// echoes the word-aligned request address alongside each returned word.
module mem_read_responder #(
  parameter int LATENCY        = 4,
  parameter int WORD_ADDR_BITS = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
`ifdef MEM_RESP_ADDR_ECHO_EN
  output logic [15:0] resp_addr,
`endif
  output logic        data_valid
);

  localparam int DEPTH = 1 << WORD_ADDR_BITS;

  // Storage array; deliberately not reset so contents survive a reset pulse.
  logic [15:0] mem_array [DEPTH];

  logic [WORD_ADDR_BITS-1:0] word_idx;
  logic                      read_req;
  logic                      write_req;

  // Byte address bit 0 and any bits above the word index are ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^addr;

  assign word_idx  = addr[WORD_ADDR_BITS:1];
  assign read_req  = enable & ~wr;
  assign write_req = enable & wr;

  // Read pipeline: stage 0 is loaded at the request edge, the last stage feeds the output register.
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [15:0]        dat_q [LATENCY];
  logic [15:0]        dat_d [LATENCY];

  logic        data_valid_q, data_valid_d;
  logic [15:0] data_out_q, data_out_d;

  // Commit writes at the edge; a read on the following edge sees the new word.
  always_ff @(posedge clk) begin
    if (write_req) begin
      mem_array[word_idx] <= data_in;
    end
  end

  // Shift the pipeline one stage per cycle; the array is sampled at the request edge (snapshot).
  always_comb begin
    vld_d    = '0;
    vld_d[0] = read_req;
    dat_d[0] = mem_array[word_idx];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Output register: pulse valid for one cycle and hold the last returned word otherwise.
  always_comb begin
    data_valid_d = vld_q[LATENCY-1];
    data_out_d   = data_out_q;
    if (vld_q[LATENCY-1]) begin
      data_out_d = dat_q[LATENCY-1];
    end
  end

  // Pipeline and output state; reset drops every in-flight read immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= 16'h0000;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= 16'h0000;
      end
    end else begin
      vld_q        <= vld_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;

`ifdef MEM_RESP_ADDR_ECHO_EN
  logic [15:0] adr_q [LATENCY];
  logic [15:0] adr_d [LATENCY];
  logic [15:0] resp_addr_q, resp_addr_d;

  // Carry the word-aligned request address alongside the data through every stage.
  always_comb begin
    adr_d[0] = {addr[15:1], 1'b0};
    for (int i = 1; i < LATENCY; i++) begin
      adr_d[i] = adr_q[i-1];
    end
    resp_addr_d = resp_addr_q;
    if (vld_q[LATENCY-1]) begin
      resp_addr_d = adr_q[LATENCY-1];
    end
  end

  // Address echo state, cleared with the rest of the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_addr_q <= 16'h0000;
      for (int i = 0; i < LATENCY; i++) begin
        adr_q[i] <= 16'h0000;
      end
    end else begin
      resp_addr_q <= resp_addr_d;
      for (int i = 0; i < LATENCY; i++) begin
        adr_q[i] <= adr_d[i];
      end
    end
  end

  assign resp_addr = resp_addr_q;
`endif

endmodule
